mult_scalable_pipe: RTL and testbench

- Pipelined, precision-scalable integer multiplier for the PIRDSP datapath.
- Generalises the fixed 8x8 full/half multiplier to WIDTH-bit operands with three packing modes: full, half (2 lanes) and quarter (4 lanes).
- Per-operand signed/unsigned control; carries each operation's mode through the pipe.
- Valid/ready handshakes at input and output with backpressure.
- Feeds the DSP accumulator/cascade stage.

---
 rtl/mult_scalable_pkg.sv | 40 ++++
 rtl/mult_scalable_core.sv | 52 +++++
 rtl/mult_scalable_pipe.sv | 129 ++++++++++++
 tb/tb_mult_scalable_pipe.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/mult_scalable_pkg.sv
// Shared definitions for the precision-scalable multiplier: packing modes,
// lane geometry helpers and the per-operation control payload.
package mult_scalable_pkg;

  typedef enum logic [1:0] {
    MODE_FULL    = 2'd0,
    MODE_HALF    = 2'd1,
    MODE_QUARTER = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_e;

  // Control fields that travel alongside the operand data; the data field
  // width depends on WIDTH, so the full payload struct is built in the pipe.
  typedef struct packed {
    logic       a_sign;
    logic       b_sign;
    logic [1:0] mode;
    logic       acc_en;
  } stage_ctl_t;

  // Number of independent lanes for a packing mode (reserved code = full).
  function automatic int unsigned lanes(input logic [1:0] mode);
    case (mode)
      MODE_HALF:    lanes = 2;
      MODE_QUARTER: lanes = 4;
      default:      lanes = 1;
    endcase
  endfunction

  // 1 when product bit bit_idx is the MSB of its lane (lane boundary),
  // for a multiplier with width-bit operands packed in the given mode.
  function automatic logic lane_mask(input int unsigned width,
                                     input logic [1:0]  mode,
                                     input int unsigned bit_idx);
    int unsigned pl;
    pl        = (2 * width) / lanes(mode);
    lane_mask = ((bit_idx % pl) == (pl - 1));
  endfunction

endpackage

// File: rtl/mult_scalable_core.sv
// Combinational lane-split multiplier core: every lane's operands are
// extracted, sign-extended per their sign flags and multiplied, and the
// partial results are masked to the lane so no carry crosses a boundary.
module mult_scalable_core
  import mult_scalable_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  input  logic               i_a_sign,
  input  logic               i_b_sign,
  input  logic [1:0]         i_mode,
  output logic [2*WIDTH-1:0] o_prod
);

  localparam int unsigned PW = 2 * WIDTH;

  logic [PW-1:0]     w_op_mask;
  logic [PW-1:0]     w_pr_mask;
  logic [PW-1:0]     w_a_ext;
  logic [PW-1:0]     w_b_ext;
  logic [PW-1:0]     w_lane_prod;
  int unsigned       w_n;
  int unsigned       w_l;

  // Per-lane product, masked to 2L bits and placed at the lane's output slot.
  // Sign extension to PW bits keeps each lane exact modulo 2^(2L).
  always_comb begin
    o_prod      = '0;
    w_a_ext     = '0;
    w_b_ext     = '0;
    w_lane_prod = '0;
    w_n         = lanes(i_mode);
    w_l         = WIDTH / w_n;
    w_op_mask   = (PW'(1) << w_l) - PW'(1);
    w_pr_mask   = (PW'(1) << (2 * w_l)) - PW'(1);
    for (int unsigned k = 0; k < 4; k++) begin
      if (k < w_n) begin
        w_a_ext = ({{WIDTH{1'b0}}, i_a} >> (k * w_l)) & w_op_mask;
        w_b_ext = ({{WIDTH{1'b0}}, i_b} >> (k * w_l)) & w_op_mask;
        if (i_a_sign && (|(w_a_ext & (PW'(1) << (w_l - 1)))))
          w_a_ext = w_a_ext | ~w_op_mask;
        if (i_b_sign && (|(w_b_ext & (PW'(1) << (w_l - 1)))))
          w_b_ext = w_b_ext | ~w_op_mask;
        w_lane_prod = w_a_ext * w_b_ext;
        o_prod      = o_prod | ((w_lane_prod & w_pr_mask) << (2 * k * w_l));
      end
    end
  end

endmodule

// File: rtl/mult_scalable_pipe.sv
// Pipelined precision-scalable multiplier (full / 2-lane / 4-lane) with
// valid/ready handshakes. Optional lane-wise accumulation at the output
// register is enabled by defining MULT_ACC_EN.
module mult_scalable_pipe
  import mult_scalable_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic               A_sign,
  input  logic               B_sign,
  input  logic [1:0]         mode,
  input  logic               acc_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] C,
  output logic [1:0]         out_mode
);

  typedef struct packed {
    logic [2*WIDTH-1:0] data;
    stage_ctl_t         ctl;
  } payload_t;

  payload_t           w_in;
  payload_t           w_last;
  logic               w_last_vld;
  logic               w_en;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_c_next;
  logic               r_out_vld;
  logic [2*WIDTH-1:0] r_c;
  logic [1:0]         r_out_mode;

  assign w_en      = ~r_out_vld | out_ready;
  assign in_ready  = w_en;
  assign out_valid = r_out_vld;
  assign C         = r_c;
  assign out_mode  = r_out_mode;

  // Capture the operation; the reserved mode code is folded to full here.
  always_comb begin
    w_in.data       = {B, A};
    w_in.ctl.a_sign = A_sign;
    w_in.ctl.b_sign = B_sign;
    w_in.ctl.mode   = (mode == MODE_RSVD) ? 2'(MODE_FULL) : mode;
    w_in.ctl.acc_en = acc_en;
  end

  generate
    if (STAGES == 1) begin : g_direct
      assign w_last     = w_in;
      assign w_last_vld = in_valid;
    end else begin : g_regs
      localparam int unsigned NREG = STAGES - 1;
      payload_t          r_stage [NREG];
      logic [NREG-1:0]   r_vld;

      // Operand pipeline: every stage advances together on the global enable.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_vld <= '0;
        end else if (w_en) begin
          r_vld[0]   <= in_valid;
          r_stage[0] <= w_in;
          for (int unsigned s = 1; s < NREG; s++) begin
            r_vld[s]   <= r_vld[s-1];
            r_stage[s] <= r_stage[s-1];
          end
        end
      end

      assign w_last     = r_stage[NREG-1];
      assign w_last_vld = r_vld[NREG-1];
    end
  endgenerate

  mult_scalable_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .i_a      (w_last.data[WIDTH-1:0]),
    .i_b      (w_last.data[2*WIDTH-1:WIDTH]),
    .i_a_sign (w_last.ctl.a_sign),
    .i_b_sign (w_last.ctl.b_sign),
    .i_mode   (w_last.ctl.mode),
    .o_prod   (w_prod)
  );

`ifdef MULT_ACC_EN
  logic [2*WIDTH-1:0] w_msb;
  logic [2*WIDTH-1:0] w_sum;

  // Lane-wise wrap-around add: carries are computed with lane MSBs cleared,
  // then the MSBs are restored by XOR so nothing leaks into the next lane.
  always_comb begin
    for (int unsigned b = 0; b < 2 * WIDTH; b++)
      w_msb[b] = lane_mask(WIDTH, w_last.ctl.mode, b);
    w_sum    = ((r_c & ~w_msb) + (w_prod & ~w_msb)) ^ ((r_c ^ w_prod) & w_msb);
    w_c_next = (w_last.ctl.acc_en && (w_last.ctl.mode == r_out_mode)) ? w_sum : w_prod;
  end
`else
  logic w_unused_acc;
  assign w_unused_acc = w_last.ctl.acc_en;
  assign w_c_next     = w_prod;
`endif

  // Output register: loads only on a valid operation so that C and the
  // previously loaded mode are the accumulator state; holds under stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_vld  <= 1'b0;
      r_c        <= '0;
      r_out_mode <= '0;
    end else if (w_en) begin
      r_out_vld <= w_last_vld;
      if (w_last_vld) begin
        r_c        <= w_c_next;
        r_out_mode <= w_last.ctl.mode;
      end
    end
  end

endmodule

// File: tb/tb_mult_scalable_pipe.sv
// Directed self-checking bench for mult_scalable_pipe (WIDTH=8, STAGES=2).
// Expected values for the accumulate sequence depend on MULT_ACC_EN.
module tb_mult_scalable_pipe;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  A;
  logic [7:0]  B;
  logic        A_sign;
  logic        B_sign;
  logic [1:0]  mode;
  logic        acc_en;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] C;
  logic [1:0]  out_mode;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

`ifdef MULT_ACC_EN
  localparam logic [15:0] ACC2_EXP = 16'h0200;
`else
  localparam logic [15:0] ACC2_EXP = 16'h0100;
`endif

  mult_scalable_pipe #(
    .WIDTH  (8),
    .STAGES (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .A_sign    (A_sign),
    .B_sign    (B_sign),
    .mode      (mode),
    .acc_en    (acc_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .C         (C),
    .out_mode  (out_mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout observed=no_finish expected=finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Single operation with an empty pipe: checks latency, C and out_mode.
  task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic as, input logic bs, input logic [1:0] m,
                       input logic ae, input logic [15:0] ec, input logic [1:0] em);
    A = a; B = b; A_sign = as; B_sign = bs; mode = m; acc_en = ae;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, " early out_valid"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check({tag, " out_valid"}, 32'(out_valid), 32'd1);
    check({tag, " C"}, 32'(C), 32'(ec));
    check({tag, " out_mode"}, 32'(out_mode), 32'(em));
  endtask

  initial begin
    int  n_sent;
    int  n_got;
    int  seen;
    logic took_in;

    reset = 1'b1; in_valid = 1'b0; A = '0; B = '0; A_sign = 1'b0; B_sign = 1'b0;
    mode = 2'd0; acc_en = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset C", 32'(C), 32'd0);
    check("reset out_mode", 32'(out_mode), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd1);
    reset = 1'b0;

    do_op("full_unsigned", 8'hFF, 8'hFF, 1'b0, 1'b0, 2'd0, 1'b0, 16'hFE01, 2'd0);
    do_op("full_signed",   8'h80, 8'h7F, 1'b1, 1'b1, 2'd0, 1'b0, 16'hC080, 2'd0);
    do_op("half_signed",   8'h7F, 8'h83, 1'b1, 1'b1, 2'd1, 1'b0, 16'hC8FD, 2'd1);
    do_op("full_mixed",    8'hFF, 8'hFF, 1'b1, 1'b0, 2'd0, 1'b0, 16'hFF01, 2'd0);
    do_op("quarter_signed", 8'hFF, 8'h55, 1'b1, 1'b1, 2'd2, 1'b0, 16'hFFFF, 2'd2);
    do_op("mode3_as_full", 8'h02, 8'h03, 1'b0, 1'b0, 2'd3, 1'b0, 16'h0006, 2'd0);

    // Back-to-back quarter then full, no flush between them.
    A = 8'hFF; B = 8'hFF; A_sign = 1'b0; B_sign = 1'b0; mode = 2'd2; in_valid = 1'b1;
    @(posedge clk); #1;
    A = 8'h02; B = 8'h03; mode = 2'd0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("b2b quarter out_valid", 32'(out_valid), 32'd1);
    check("b2b quarter C", 32'(C), 32'h9999);
    check("b2b quarter out_mode", 32'(out_mode), 32'd2);
    @(posedge clk); #1;
    check("b2b full out_valid", 32'(out_valid), 32'd1);
    check("b2b full C", 32'(C), 32'h0006);
    check("b2b full out_mode", 32'(out_mode), 32'd0);
    @(posedge clk); #1;
    check("drained out_valid", 32'(out_valid), 32'd0);

    // Backpressure: four ops, out_ready low for the first four cycles.
    n_sent = 0; n_got = 0;
    B = 8'd2; mode = 2'd0;
    for (int cyc = 0; cyc < 40 && n_got < 4; cyc++) begin
      out_ready = (cyc >= 4);
      in_valid  = (n_sent < 4);
      A         = 8'(n_sent + 1);
      #1;
      if (cyc == 2) begin
        check("bp in_ready full", 32'(in_ready), 32'd0);
        check("bp out_valid held", 32'(out_valid), 32'd1);
      end
      took_in = in_valid & in_ready;
      if (out_valid & out_ready) begin
        check("bp output C", 32'(C), 32'(2 * (n_got + 1)));
        n_got++;
      end
      @(posedge clk); #1;
      if (took_in) n_sent++;
    end
    in_valid = 1'b0;
    check("bp outputs received", 32'(n_got), 32'd4);
    check("bp ops accepted", 32'(n_sent), 32'd4);
    check("bp no duplicate", 32'(out_valid), 32'd0);

    // Reset during a stall discards in-flight work.
    out_ready = 1'b0;
    A = 8'd5; in_valid = 1'b1;
    @(posedge clk); #1;
    A = 8'd6;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("stall out_valid", 32'(out_valid), 32'd1);
    check("stall in_ready", 32'(in_ready), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("mid-stall reset out_valid", 32'(out_valid), 32'd0);
    check("mid-stall reset C", 32'(C), 32'd0);
    reset = 1'b0;
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      seen += int'(out_valid);
    end
    check("no stale outputs", 32'(seen), 32'd0);

    // Accumulate sequence (acc_en only honoured with MULT_ACC_EN).
    do_op("acc first",   8'h10, 8'h10, 1'b0, 1'b0, 2'd0, 1'b0, 16'h0100, 2'd0);
    do_op("acc second",  8'h10, 8'h10, 1'b0, 1'b0, 2'd0, 1'b1, ACC2_EXP, 2'd0);
    do_op("acc restart", 8'h11, 8'h11, 1'b0, 1'b0, 2'd1, 1'b1, 16'h0101, 2'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
